// File: rtl/ghost_motion_pkg.sv
// ghost_motion_pkg: shared direction encodings, maze geometry and FSM state type
// for the ghost tile-walking logic.
package ghost_motion_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    localparam int H_VISIBLE_START = 336;
    localparam int V_VISIBLE_START = 27;
    localparam int MOVE_TO_CENTER  = 7;
    localparam int SCALING_FACTOR  = 16;
    localparam int MAZE_COLS       = 40;
    localparam int MAZE_ROWS       = 30;

    typedef enum logic [1:0] {IDLE, DECIDE, WAIT, MOVE} state_t;

    // Right<->left and down<->up swap adjacent bit pairs.
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic logic [10:0] centre_x(input logic [6:0] col);
        return 11'(col) * 11'(SCALING_FACTOR) + 11'(H_VISIBLE_START + MOVE_TO_CENTER);
    endfunction

    function automatic logic [9:0] centre_y(input logic [5:0] row);
        return 10'(row) * 10'(SCALING_FACTOR) + 10'(V_VISIBLE_START + MOVE_TO_CENTER);
    endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// ghost_dir_select: picks the committed direction from the controller request,
// falling back to continuing straight, then reversing, then none.
module ghost_dir_select
    import ghost_motion_pkg::*;
(
    input  logic [3:0] move_direction,
    input  logic [3:0] valid_moves,
    input  logic [3:0] prev_direction,
    output logic [3:0] sel,
    output logic       found
);

    logic       one_hot;
    logic [3:0] rev;

    always_comb begin
        one_hot = (move_direction != DIR_NONE) && ((move_direction & (move_direction - 4'd1)) == DIR_NONE);
        rev     = reverse_dir(prev_direction);
        sel     = (one_hot && (move_direction & valid_moves) != DIR_NONE) ? move_direction :
                  ((prev_direction & valid_moves) != DIR_NONE)          ? prev_direction :
                  ((rev & valid_moves) != DIR_NONE)                     ? rev : DIR_NONE;
        found   = sel != DIR_NONE;
    end

endmodule

// File: rtl/ghost_motion.sv
// ghost_motion: walks a ghost tile by tile, requesting a direction decision at
// each tile centre and stepping one pixel per tick over the 16-pixel tile.
module ghost_motion
    import ghost_motion_pkg::*;
#(
    parameter int START_COL   = 28,
    parameter int START_ROW   = 21,
    parameter int DECIDE_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_en,
    input  logic        tick,
    input  logic [3:0]  move_direction,
    input  logic [3:0]  valid_moves,
    output logic        decide_req,
    output logic [10:0] ghost_curr_pos_x,
    output logic [9:0]  ghost_curr_pos_y,
    output logic [6:0]  ghost_mat_idx_x,
    output logic [5:0]  ghost_mat_idx_y,
    output logic [3:0]  prev_direction
);

    localparam logic [6:0] LAST_COL = 7'(MAZE_COLS - 1);
    localparam logic [7:0] WAIT_END = 8'(DECIDE_WAIT);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic [3:0]  offset;
    logic [3:0]  sel;
    logic        found;
    logic        sample;
    logic        tile_done;
    logic [6:0]  next_col;
    logic [5:0]  next_row;
    logic [10:0] step_x;
    logic [9:0]  step_y;

    ghost_dir_select u_dir_select (
        .move_direction(move_direction),
        .valid_moves(valid_moves),
        .prev_direction(prev_direction),
        .sel(sel),
        .found(found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // wait_cnt runs past WAIT_END after a failed sample so the choice is made once per decision.
    always_comb begin
        sample     = (state == WAIT) && (wait_cnt == WAIT_END);
        tile_done  = (state == MOVE) && tick && (offset == 4'd15);
        decide_req = state == DECIDE;
        state_next = state;
        case (state)
            IDLE:    state_next = move_en ? DECIDE : IDLE;
            DECIDE:  state_next = move_en ? WAIT : IDLE;
            WAIT:    state_next = !move_en ? IDLE :
                                  (wait_cnt < WAIT_END) ? WAIT :
                                  (sample && found) ? MOVE :
                                  tick ? DECIDE : WAIT;
            MOVE:    state_next = !tile_done ? MOVE : move_en ? DECIDE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        next_col = (prev_direction == DIR_RIGHT) ? ((ghost_mat_idx_x == LAST_COL) ? 7'd0 : ghost_mat_idx_x + 7'd1) :
                   (prev_direction == DIR_LEFT)  ? ((ghost_mat_idx_x == 7'd0) ? LAST_COL : ghost_mat_idx_x - 7'd1) :
                   ghost_mat_idx_x;
        next_row = (prev_direction == DIR_DOWN) ? ghost_mat_idx_y + 6'd1 :
                   (prev_direction == DIR_UP)   ? ghost_mat_idx_y - 6'd1 : ghost_mat_idx_y;
        step_x   = (prev_direction == DIR_RIGHT) ? ghost_curr_pos_x + 11'd1 :
                   (prev_direction == DIR_LEFT)  ? ghost_curr_pos_x - 11'd1 : ghost_curr_pos_x;
        step_y   = (prev_direction == DIR_DOWN) ? ghost_curr_pos_y + 10'd1 :
                   (prev_direction == DIR_UP)   ? ghost_curr_pos_y - 10'd1 : ghost_curr_pos_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghost_mat_idx_x  <= 7'(START_COL);
            ghost_mat_idx_y  <= 6'(START_ROW);
            ghost_curr_pos_x <= centre_x(7'(START_COL));
            ghost_curr_pos_y <= centre_y(6'(START_ROW));
            prev_direction   <= DIR_RIGHT;
            offset           <= 4'd0;
            wait_cnt         <= 8'd0;
        end else begin
            if (state == DECIDE)
                wait_cnt <= 8'd1;
            else if (state == WAIT && wait_cnt <= WAIT_END)
                wait_cnt <= wait_cnt + 8'd1;
            if (sample && move_en && found) begin
                prev_direction <= sel;
                offset         <= 4'd0;
            end
            if (state == MOVE && tick) begin
                if (offset == 4'd15) begin
                    ghost_mat_idx_x  <= next_col;
                    ghost_mat_idx_y  <= next_row;
                    ghost_curr_pos_x <= centre_x(next_col);
                    ghost_curr_pos_y <= centre_y(next_row);
                    offset           <= 4'd0;
                end else begin
                    ghost_curr_pos_x <= step_x;
                    ghost_curr_pos_y <= step_y;
                    offset           <= offset + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_motion.sv
// tb_ghost_motion: scenario tasks plus a randomized walk checked against a
// tile-level reference model of the ghost.
module tb_ghost_motion;

    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_en;
    logic        tick;
    logic [3:0]  move_direction;
    logic [3:0]  valid_moves;
    logic        decide_req;
    logic [10:0] ghost_curr_pos_x;
    logic [9:0]  ghost_curr_pos_y;
    logic [6:0]  ghost_mat_idx_x;
    logic [5:0]  ghost_mat_idx_y;
    logic [3:0]  prev_direction;

    int vectors = 0;
    int miscompares = 0;
    int m_col, m_row;
    logic [3:0] m_prev;

    ghost_motion #(.START_COL(28), .START_ROW(21), .DECIDE_WAIT(DW)) dut (
        .clk(clk),
        .rst(rst),
        .move_en(move_en),
        .tick(tick),
        .move_direction(move_direction),
        .valid_moves(valid_moves),
        .decide_req(decide_req),
        .ghost_curr_pos_x(ghost_curr_pos_x),
        .ghost_curr_pos_y(ghost_curr_pos_y),
        .ghost_mat_idx_x(ghost_mat_idx_x),
        .ghost_mat_idx_y(ghost_mat_idx_y),
        .prev_direction(prev_direction)
    );

    always #5 clk = ~clk;

    function automatic int exp_x(input int c);
        return c * 16 + 343;
    endfunction

    function automatic int exp_y(input int r);
        return r * 16 + 34;
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            4'b0001: return 4'b0010;
            4'b0010: return 4'b0001;
            4'b0100: return 4'b1000;
            4'b1000: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] req, input logic [3:0] val, input logic [3:0] prev);
        if ($countones(req) == 1 && (req & val) != 0) return req;
        if ((prev & val) != 0) return prev;
        if ((opposite(prev) & val) != 0) return opposite(prev);
        return 4'b0000;
    endfunction

    function automatic int dx(input logic [3:0] d);
        return d == 4'b0001 ? 1 : d == 4'b0010 ? -1 : 0;
    endfunction

    function automatic int dy(input logic [3:0] d);
        return d == 4'b0100 ? 1 : d == 4'b1000 ? -1 : 0;
    endfunction

    task automatic model_step(input logic [3:0] d);
        m_col  = (m_col + dx(d) + 40) % 40;
        m_row  = m_row + dy(d);
        m_prev = d;
    endtask

    task automatic wait_decide();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (decide_req === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL decide_timeout: decide_req never rose, got %b required 1", decide_req);
        end
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] val);
        move_direction = req;
        valid_moves    = val;
        repeat (DW + 1) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; move_en = 1'b0; tick = 1'b0; move_direction = 4'b0001; valid_moves = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_col = 28; m_row = 21; m_prev = 4'b0001;
        vectors++;
        if ({ghost_mat_idx_x, ghost_mat_idx_y, ghost_curr_pos_x, ghost_curr_pos_y} !== {7'd28, 6'd21, 11'd791, 10'd370}) begin
            miscompares++;
            $display("FAIL reset_pos: got idx (%0d,%0d) pos (%0d,%0d) required idx (28,21) pos (791,370)",
                     ghost_mat_idx_x, ghost_mat_idx_y, ghost_curr_pos_x, ghost_curr_pos_y);
        end
        vectors++;
        if ({prev_direction, decide_req} !== {4'b0001, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got prev %b decide %b required prev 0001 decide 0", prev_direction, decide_req);
        end
    endtask

    task automatic test_basic();
        move_direction = 4'b0001; valid_moves = 4'b0101;
        move_en = 1'b1;
        wait_decide();
        @(negedge clk);
        vectors++;
        if (decide_req !== 1'b0) begin
            miscompares++;
            $display("FAIL decide_one_cycle: got %b required 0", decide_req);
        end
        repeat (DW) @(negedge clk);
        ticks(16);
        model_step(4'b0001);
        vectors++;
        if ({ghost_curr_pos_x, ghost_mat_idx_x, decide_req} !== {11'd807, 7'd29, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_move: got x %0d col %0d decide %b required x 807 col 29 decide 1",
                     ghost_curr_pos_x, ghost_mat_idx_x, decide_req);
        end
    endtask

    task automatic test_fallback();
        wait_decide();
        apply(4'b0100, 4'b0001);
        vectors++;
        if (prev_direction !== 4'b0001) begin
            miscompares++;
            $display("FAIL fallback_prev: got %b required 0001", prev_direction);
        end
        ticks(16);
        model_step(4'b0001);
        vectors++;
        if ({ghost_curr_pos_x, ghost_mat_idx_x} !== {11'd823, 7'd30}) begin
            miscompares++;
            $display("FAIL fallback_move: got x %0d col %0d required x 823 col 30", ghost_curr_pos_x, ghost_mat_idx_x);
        end
    endtask

    task automatic test_reverse();
        wait_decide();
        apply(4'b1000, 4'b0010);
        ticks(16);
        model_step(4'b0010);
        vectors++;
        if ({prev_direction, ghost_curr_pos_x, ghost_mat_idx_x, ghost_mat_idx_y} !== {4'b0010, 11'd807, 7'd29, 6'd21}) begin
            miscompares++;
            $display("FAIL reverse_move: got prev %b x %0d idx (%0d,%0d) required prev 0010 x 807 idx (29,21)",
                     prev_direction, ghost_curr_pos_x, ghost_mat_idx_x, ghost_mat_idx_y);
        end
    endtask

    task automatic test_stall();
        wait_decide();
        repeat (2) begin
            apply(4'b0001, 4'b0000);
            vectors++;
            if ({ghost_curr_pos_x, ghost_curr_pos_y, decide_req} !== {11'(exp_x(m_col)), 10'(exp_y(m_row)), 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold: got x %0d y %0d decide %b required x %0d y %0d decide 0",
                         ghost_curr_pos_x, ghost_curr_pos_y, decide_req, exp_x(m_col), exp_y(m_row));
            end
            ticks(1);
            vectors++;
            if (decide_req !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_redecide: got decide %b required 1", decide_req);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 45 && m_col != 0; i++) begin
            wait_decide();
            apply(4'b0010, 4'b0011);
            ticks(16);
            model_step(4'b0010);
        end
        vectors++;
        if ({ghost_mat_idx_x, ghost_curr_pos_x} !== {7'd0, 11'd343}) begin
            miscompares++;
            $display("FAIL walk_to_col0: got col %0d x %0d required col 0 x 343", ghost_mat_idx_x, ghost_curr_pos_x);
        end
        wait_decide();
        apply(4'b0010, 4'b0011);
        ticks(8);
        vectors++;
        if (ghost_curr_pos_x !== 11'd335) begin
            miscompares++;
            $display("FAIL wrap_left_mid: got x %0d required 335", ghost_curr_pos_x);
        end
        ticks(8);
        model_step(4'b0010);
        vectors++;
        if ({ghost_mat_idx_x, ghost_curr_pos_x} !== {7'd39, 11'd967}) begin
            miscompares++;
            $display("FAIL wrap_left: got col %0d x %0d required col 39 x 967", ghost_mat_idx_x, ghost_curr_pos_x);
        end
        wait_decide();
        apply(4'b0001, 4'b0011);
        ticks(16);
        model_step(4'b0001);
        vectors++;
        if ({ghost_mat_idx_x, ghost_curr_pos_x} !== {7'd0, 11'd343}) begin
            miscompares++;
            $display("FAIL wrap_right: got col %0d x %0d required col 0 x 343", ghost_mat_idx_x, ghost_curr_pos_x);
        end
    endtask

    task automatic test_enable_drop();
        wait_decide();
        apply(4'b0001, 4'b0001);
        ticks(3);
        move_en = 1'b0;
        ticks(13);
        model_step(4'b0001);
        vectors++;
        if ({ghost_mat_idx_x, ghost_curr_pos_x, decide_req} !== {7'(m_col), 11'(exp_x(m_col)), 1'b0}) begin
            miscompares++;
            $display("FAIL drop_in_move: got col %0d x %0d decide %b required col %0d x %0d decide 0",
                     ghost_mat_idx_x, ghost_curr_pos_x, decide_req, m_col, exp_x(m_col));
        end
        ticks(2);
        vectors++;
        if ({ghost_curr_pos_x, decide_req} !== {11'(exp_x(m_col)), 1'b0}) begin
            miscompares++;
            $display("FAIL idle_ignores_tick: got x %0d decide %b required x %0d decide 0",
                     ghost_curr_pos_x, decide_req, exp_x(m_col));
        end
        @(negedge clk) move_en = 1'b1;
        @(negedge clk);
        wait_decide();
        move_en = 1'b0;
        apply(4'b0001, 4'b0001);
        ticks(4);
        vectors++;
        if ({ghost_curr_pos_x, ghost_mat_idx_x, decide_req} !== {11'(exp_x(m_col)), 7'(m_col), 1'b0}) begin
            miscompares++;
            $display("FAIL drop_in_decide: got x %0d col %0d decide %b required x %0d col %0d decide 0",
                     ghost_curr_pos_x, ghost_mat_idx_x, decide_req, exp_x(m_col), m_col);
        end
    endtask

    task automatic test_reset_mid();
        move_en = 1'b1;
        @(negedge clk);
        wait_decide();
        apply(4'b0001, 4'b0001);
        ticks(5);
        vectors++;
        if (ghost_curr_pos_x !== 11'(exp_x(m_col) + 5)) begin
            miscompares++;
            $display("FAIL pre_reset_step: got x %0d required %0d", ghost_curr_pos_x, exp_x(m_col) + 5);
        end
        move_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_col = 28; m_row = 21; m_prev = 4'b0001;
        vectors++;
        if ({ghost_curr_pos_x, ghost_curr_pos_y, ghost_mat_idx_x, ghost_mat_idx_y, prev_direction, decide_req}
            !== {11'd791, 10'd370, 7'd28, 6'd21, 4'b0001, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got pos (%0d,%0d) idx (%0d,%0d) prev %b decide %b required (791,370) (28,21) 0001 0",
                     ghost_curr_pos_x, ghost_curr_pos_y, ghost_mat_idx_x, ghost_mat_idx_y, prev_direction, decide_req);
        end
        @(negedge clk) rst = 1'b0;
        ticks(2);
        vectors++;
        if ({ghost_curr_pos_x, decide_req} !== {11'd791, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_idle: got x %0d decide %b required x 791 decide 0", ghost_curr_pos_x, decide_req);
        end
        move_en = 1'b1;
        @(negedge clk);
        wait_decide();
        apply(4'b0001, 4'b0001);
        ticks(16);
        model_step(4'b0001);
        vectors++;
        if ({ghost_curr_pos_x, ghost_mat_idx_x} !== {11'd807, 7'd29}) begin
            miscompares++;
            $display("FAIL offset_cleared: got x %0d col %0d required x 807 col 29", ghost_curr_pos_x, ghost_mat_idx_x);
        end
    endtask

    task automatic test_random();
        logic [3:0] req, val, sel;
        for (int n = 0; n < 40; n++) begin
            wait_decide();
            req = ($urandom_range(0, 3) < 2) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            val = 4'($urandom);
            if (m_row == 0) val[3] = 1'b0;
            if (m_row == 29) val[2] = 1'b0;
            sel = m_sel(req, val, m_prev);
            apply(req, val);
            if (sel != 4'b0000) begin
                ticks(8);
                vectors++;
                if ({ghost_curr_pos_x, ghost_curr_pos_y} !== {11'(exp_x(m_col) + 8 * dx(sel)), 10'(exp_y(m_row) + 8 * dy(sel))}) begin
                    miscompares++;
                    $display("FAIL rand_mid[%0d]: got (%0d,%0d) required (%0d,%0d)", n, ghost_curr_pos_x, ghost_curr_pos_y,
                             exp_x(m_col) + 8 * dx(sel), exp_y(m_row) + 8 * dy(sel));
                end
                ticks(8);
                model_step(sel);
            end else begin
                ticks(1);
            end
            vectors++;
            if ({ghost_mat_idx_x, ghost_mat_idx_y, ghost_curr_pos_x, ghost_curr_pos_y, prev_direction, decide_req}
                !== {7'(m_col), 6'(m_row), 11'(exp_x(m_col)), 10'(exp_y(m_row)), m_prev, 1'b1}) begin
                miscompares++;
                $display("FAIL rand_tile[%0d]: got idx (%0d,%0d) pos (%0d,%0d) prev %b decide %b required idx (%0d,%0d) pos (%0d,%0d) prev %b decide 1",
                         n, ghost_mat_idx_x, ghost_mat_idx_y, ghost_curr_pos_x, ghost_curr_pos_y, prev_direction, decide_req,
                         m_col, m_row, exp_x(m_col), exp_y(m_row), m_prev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fallback();
        test_reverse();
        test_stall();
        test_wrap();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
